// File: rtl/alu_pkg.sv
// Shared opcode, state and instruction-field definitions for the ALU sequencer.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_XOR  = 4'b0010, OP_NOT  = 4'b0011,
    OP_ADD  = 4'b0100, OP_SUB  = 4'b0101, OP_SHL  = 4'b0110, OP_SHR  = 4'b0111,
    OP_ADDI = 4'b1000, OP_SUBI = 4'b1001, OP_MOVI = 4'b1010, OP_NOP  = 4'b1011,
    OP_ILL0 = 4'b1100, OP_ILL1 = 4'b1101, OP_ILL2 = 4'b1110, OP_HALT = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  localparam int OP_MSB  = 16;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 9;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MOVI);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return !((op == OP_ILL0) || (op == OP_ILL1) || (op == OP_ILL2));
  endfunction

endpackage

// File: rtl/regfile4x9.sv
// Four-entry register file: synchronous write with reset-to-zero,
// two asynchronous operand read ports and one asynchronous debug read port.
module regfile4x9 #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [4];

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Control end of the ALU opcode interface: fetch, decode, operand issue and writeback
// around an external combinational 9-bit ALU.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int DATA_W  = 9,
  parameter int INSTR_W = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               instr_req,
  output logic [PC_W-1:0]    instr_addr,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [3:0]         alu_opcode,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op,
  output logic [PC_W-1:0]    pc,
  input  logic [1:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e             state, next_state;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  result;
  logic [3:0]         op;
  logic [1:0]         rd, rs;
  logic [8:0]         imm;
  logic [DATA_W-1:0]  rdata_a, rdata_b;
  logic               we;

  assign op  = instr[OP_MSB:OP_LSB];
  assign rd  = instr[RD_MSB:RD_LSB];
  assign rs  = instr[RS_MSB:RS_LSB];
  assign imm = instr[IMM_MSB:IMM_LSB];

  // NOP, HALT and illegal opcodes never write; they bypass EXEC entirely.
  assign we = (state == S_WB) && is_legal_op(op) && (op != OP_NOP) && (op != OP_HALT);

  regfile4x9 #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (rd),
    .wdata    (result),
    .raddr_a  (rs),
    .raddr_b  (imm[1:0]),
    .dbg_sel  (dbg_sel),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .dbg_data (dbg_data)
  );

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_FETCH;
        else       next_state = S_IDLE;
      end
      S_FETCH: begin
        if (instr_valid) next_state = S_DECODE;
        else             next_state = S_FETCH;
      end
      S_DECODE: begin
        if (op == OP_HALT)                          next_state = S_HALTED;
        else if (!is_legal_op(op) || op == OP_NOP)  next_state = S_WB;
        else                                        next_state = S_EXEC;
      end
      S_EXEC:   next_state = S_WB;
      S_WB:     next_state = S_FETCH;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_IDLE;
    endcase
  end

  // Sequencer state, instruction latch, ALU operand issue and pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      instr      <= '0;
      result     <= '0;
      pc         <= '0;
      illegal_op <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= OP_NOP;
    end else begin
      state <= next_state;
      if (state == S_FETCH && instr_valid) instr <= instr_data;
      // Operands are registered on entry to EXEC so the ALU sees them for the whole cycle.
      if (state == S_DECODE && next_state == S_EXEC) begin
        alu_opcode <= op;
        alu_a      <= rdata_a;
        alu_b      <= is_imm_op(op) ? DATA_W'(imm) : rdata_b;
      end else begin
        alu_opcode <= OP_NOP;
      end
      if (state == S_EXEC) result <= alu_out;
      if (state == S_DECODE && !is_legal_op(op)) illegal_op <= 1'b1;
      if (state == S_WB) pc <= pc + PC_W'(1);
    end
  end

  assign instr_req  = (state == S_FETCH);
  assign instr_addr = pc;
  assign busy       = (state == S_FETCH) || (state == S_DECODE) ||
                      (state == S_EXEC)  || (state == S_WB);
  assign halted     = (state == S_HALTED);

endmodule
